// File: rtl/gpu_mem_arb_if.sv
// Bus bundle between four burst requesters and the single memory port of gpu_mem_arb.
interface gpu_mem_arb_if #(
  parameter int WIDTH = 32
);
  logic [3:0]         req_valid_i;
  logic [4*WIDTH-1:0] req_data_i;
  logic [3:0]         req_last_i;
  logic [3:0]         req_pop_o;
  logic               mem_valid_o;
  logic [WIDTH-1:0]   mem_data_o;
  logic               mem_last_o;
  logic [1:0]         mem_src_o;
  logic               mem_accept_i;
  logic               timeout_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, mem_accept_i,
    output req_pop_o, mem_valid_o, mem_data_o, mem_last_o, mem_src_o, timeout_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, mem_accept_i,
    input  req_pop_o, mem_valid_o, mem_data_o, mem_last_o, mem_src_o, timeout_o
  );
endinterface

// File: rtl/gpu_mem_arb.sv
// Four-way round-robin burst arbiter onto one memory port; a grant is held until the last beat.
// Define GPU_MEM_ARB_WDOG_EN to build in the stall watchdog that releases a stuck grant.
module gpu_mem_arb #(
  parameter int WIDTH    = 32,
  parameter int WDOG_CYC = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  gpu_mem_arb_if.slave bus
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       grant_reg, grant_next;
  logic [1:0]       rr_ptr_reg, rr_ptr_next;
  logic [WIDTH-1:0] data_arr [4];
  logic [3:0]       rot_valid;
  logic [1:0]       pick;
  logic             timeout;

  // rot_valid[gi] is the requester gi places after the round-robin pointer
  for (genvar gi = 0; gi < 4; gi++) begin : g_req
    assign data_arr[gi]  = bus.req_data_i[gi*WIDTH +: WIDTH];
    assign rot_valid[gi] = bus.req_valid_i[rr_ptr_reg + 2'(gi)];
  end

  always_comb begin
    pick = rr_ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (rot_valid[i]) pick = rr_ptr_reg + 2'(i);
    end
  end

`ifdef GPU_MEM_ARB_WDOG_EN
  logic       stall;
  logic [7:0] wdog_cnt_reg, wdog_cnt_next;

  assign stall = (state_reg == LOCK) && !bus.req_valid_i[grant_reg];

  // Fires on the WDOG_CYC-th consecutive stall cycle; counter restarts from zero.
  always_comb begin
    timeout       = 1'b0;
    wdog_cnt_next = 8'd0;
    if (stall) begin
      if (wdog_cnt_reg == 8'(WDOG_CYC - 1)) timeout = 1'b1;
      else wdog_cnt_next = wdog_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wdog_cnt_reg <= 8'd0;
    else       wdog_cnt_reg <= wdog_cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    bus.req_pop_o   = 4'b0000;
    bus.mem_valid_o = 1'b0;
    bus.mem_data_o  = '0;
    bus.mem_last_o  = 1'b0;
    bus.mem_src_o   = 2'd0;
    bus.timeout_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|bus.req_valid_i) begin
          grant_next = pick;
          state_next = LOCK;
        end
      end
      LOCK: begin
        bus.mem_valid_o = bus.req_valid_i[grant_reg];
        bus.mem_data_o  = data_arr[grant_reg];
        bus.mem_last_o  = bus.req_last_i[grant_reg] & bus.req_valid_i[grant_reg];
        bus.mem_src_o   = grant_reg;
        bus.timeout_o   = timeout;
        if (bus.req_valid_i[grant_reg] && bus.mem_accept_i) begin
          bus.req_pop_o[grant_reg] = 1'b1;
          if (bus.req_last_i[grant_reg]) begin
            state_next  = IDLE;
            rr_ptr_next = grant_reg + 2'd1;
          end
        end
        if (timeout) begin
          state_next  = IDLE;
          rr_ptr_next = grant_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Nothing is popped or presented while reset is held, so no beat is half-consumed.
    if (rst_i) begin
      bus.req_pop_o   = 4'b0000;
      bus.mem_valid_o = 1'b0;
      bus.mem_data_o  = '0;
      bus.mem_last_o  = 1'b0;
      bus.mem_src_o   = 2'd0;
      bus.timeout_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      grant_reg  <= 2'd0;
      rr_ptr_reg <= 2'd0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end
endmodule

// File: tb/tb_gpu_mem_arb.sv
// Directed bench for gpu_mem_arb: burst transfer, round-robin order, backpressure, lock, reset, watchdog.
module tb_gpu_mem_arb;
  localparam int WIDTH = 32;

  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_fail;
  int   pops [4];

  gpu_mem_arb_if #(.WIDTH(WIDTH)) bus ();

  gpu_mem_arb #(.WIDTH(WIDTH), .WDOG_CYC(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One line per transferred beat, plus per-requester pop tally.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int n = 0; n < 4; n++) if (bus.req_pop_o[n]) pops[n]++;
      if (bus.mem_valid_o && bus.mem_accept_i)
        $display("xfer src=%0d data=%08h last=%0b", bus.mem_src_o, bus.mem_data_o, bus.mem_last_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [WIDTH-1:0] d, input logic l);
    bus.req_valid_i[n]             = v;
    bus.req_data_i[n*WIDTH +: WIDTH] = d;
    bus.req_last_i[n]              = l;
  endtask

  task automatic clear_reqs();
    bus.req_valid_i = 4'b0000;
    bus.req_last_i  = 4'b0000;
    bus.req_data_i  = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(bus.mem_valid_o), 64'd0);
    check({tag, "_pop"},   64'(bus.req_pop_o),   64'd0);
    check({tag, "_src"},   64'(bus.mem_src_o),   64'd0);
    check({tag, "_last"},  64'(bus.mem_last_o),  64'd0);
  endtask

  task automatic check_beat(input string tag, input int src, input logic [WIDTH-1:0] d, input logic l);
    logic [3:0] exp_pop;
    exp_pop = bus.mem_accept_i ? (4'b0001 << src) : 4'b0000;
    check({tag, "_valid"}, 64'(bus.mem_valid_o), 64'd1);
    check({tag, "_src"},   64'(bus.mem_src_o),   64'(src));
    check({tag, "_data"},  64'(bus.mem_data_o),  64'(d));
    check({tag, "_last"},  64'(bus.mem_last_o),  64'(l));
    check({tag, "_pop"},   64'(bus.req_pop_o),   64'(exp_pop));
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: got no end expected end of test");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int n = 0; n < 4; n++) pops[n] = 0;
    rst_i            = 1'b1;
    bus.mem_accept_i = 1'b0;
    clear_reqs();
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    check_idle("reset");
    check("reset_timeout", 64'(bus.timeout_o), 64'd0);

    // Single 3-beat burst on requester 2
    for (int n = 0; n < 4; n++) pops[n] = 0;
    bus.mem_accept_i = 1'b1;
    set_req(2, 1'b1, 32'hA0, 1'b0);
    #1 check_idle("sb_arb");
    step(); #1 check_beat("sb_b0", 2, 32'hA0, 1'b0);
    step(); set_req(2, 1'b1, 32'hA1, 1'b0);
    #1 check_beat("sb_b1", 2, 32'hA1, 1'b0);
    step(); set_req(2, 1'b1, 32'hA2, 1'b1);
    #1 check_beat("sb_b2", 2, 32'hA2, 1'b1);
    step(); set_req(2, 1'b0, 32'h0, 1'b0);
    #1 check_idle("sb_done");
    check("sb_pops2", 64'(pops[2]), 64'd3);

    // rr_ptr is now 3: with requesters 0 and 3 valid, 3 wins
    set_req(0, 1'b1, 32'hB0, 1'b1);
    set_req(3, 1'b1, 32'hB3, 1'b1);
    #1 check_idle("rp_arb");
    step(); #1 check_beat("rp_g3", 3, 32'hB3, 1'b1);
    step(); clear_reqs();
    #1 check_idle("rp_done");

    // Round-robin with all four valid, 1-beat bursts: 0,1,2,3,0
    for (int n = 0; n < 4; n++) set_req(n, 1'b1, 32'hC0 + 32'(n), 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 check_idle($sformatf("rr%0d_idle", k));
      step();
      #1 check_beat($sformatf("rr%0d_beat", k), k % 4, 32'hC0 + 32'(k % 4), 1'b1);
      step();
    end
    clear_reqs();

    // Backpressure on requester 1 for 5 cycles mid-burst
    for (int n = 0; n < 4; n++) pops[n] = 0;
    set_req(1, 1'b1, 32'hD0, 1'b0);
    #1 check_idle("bp_arb");
    step(); #1 check_beat("bp_b0", 1, 32'hD0, 1'b0);
    step(); set_req(1, 1'b1, 32'hD1, 1'b0);
    bus.mem_accept_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check_beat($sformatf("bp_hold%0d", k), 1, 32'hD1, 1'b0);
      step();
    end
    bus.mem_accept_i = 1'b1;
    #1 check_beat("bp_b1", 1, 32'hD1, 1'b0);
    step(); set_req(1, 1'b1, 32'hD2, 1'b1);
    #1 check_beat("bp_b2", 1, 32'hD2, 1'b1);
    step(); clear_reqs();
    #1 check_idle("bp_done");
    check("bp_pops1", 64'(pops[1]), 64'd3);

    // Burst lock: requester 1 raises valid during requester 0's 4-beat burst
    set_req(0, 1'b1, 32'hE0, 1'b0);
    #1 check_idle("bl_arb");
    step(); #1 check_beat("bl_b0", 0, 32'hE0, 1'b0);
    step(); set_req(0, 1'b1, 32'hE1, 1'b0); set_req(1, 1'b1, 32'hF0, 1'b1);
    #1 check_beat("bl_b1", 0, 32'hE1, 1'b0);
    step(); set_req(0, 1'b1, 32'hE2, 1'b0);
    #1 check_beat("bl_b2", 0, 32'hE2, 1'b0);
    step(); set_req(0, 1'b1, 32'hE3, 1'b1);
    #1 check_beat("bl_b3", 0, 32'hE3, 1'b1);
    step(); set_req(0, 1'b0, 32'h0, 1'b0);
    #1 check_idle("bl_idle");
    step(); #1 check_beat("bl_r1", 1, 32'hF0, 1'b1);
    step(); clear_reqs();

    // Reset at beat 2 of 4 on requester 3
    set_req(3, 1'b1, 32'h30, 1'b0);
    #1 check_idle("rm_arb");
    step(); #1 check_beat("rm_b0", 3, 32'h30, 1'b0);
    step(); set_req(3, 1'b1, 32'h31, 1'b0);
    rst_i = 1'b1;
    step(); rst_i = 1'b0;
    set_req(1, 1'b1, 32'h10, 1'b1);
    #1 check_idle("rm_after");
    check("rm_timeout", 64'(bus.timeout_o), 64'd0);
    step(); #1 check_beat("rm_low", 1, 32'h10, 1'b1);
    step(); clear_reqs();

    // Requester 2 stalls after one beat while requester 0 waits
    set_req(2, 1'b1, 32'h20, 1'b0);
    #1 check_idle("wd_arb");
    step(); #1 check_beat("wd_b0", 2, 32'h20, 1'b0);
    step(); set_req(2, 1'b0, 32'h0, 1'b0); set_req(0, 1'b1, 32'h40, 1'b1);
`ifdef GPU_MEM_ARB_WDOG_EN
    for (int s = 1; s <= 16; s++) begin
      #1 check($sformatf("wd_to%0d", s), 64'(bus.timeout_o), (s == 16) ? 64'd1 : 64'd0);
      check($sformatf("wd_src%0d", s), 64'(bus.mem_src_o), 64'd2);
      check($sformatf("wd_val%0d", s), 64'(bus.mem_valid_o), 64'd0);
      step();
    end
    #1 check_idle("wd_idle");
    check("wd_to_clr", 64'(bus.timeout_o), 64'd0);
    step(); #1 check_beat("wd_next", 0, 32'h40, 1'b1);
    step(); clear_reqs();
`else
    for (int s = 1; s <= 20; s++) begin
      #1 check($sformatf("nw_to%0d", s), 64'(bus.timeout_o), 64'd0);
      check($sformatf("nw_src%0d", s), 64'(bus.mem_src_o), 64'd2);
      step();
    end
    set_req(2, 1'b1, 32'h21, 1'b1);
    #1 check_beat("nw_b1", 2, 32'h21, 1'b1);
    step(); clear_reqs();
    #1 check_idle("nw_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
